// File: rtl/card_dealer.sv
// Card dealer: deals 18 shuffled pairs into a 64-entry card memory.
// The deck is filled in order, shuffled by LFSR-driven Fisher-Yates, then streamed out.
module card_dealer #(
   parameter int         NUM_CARDS = 36,
   parameter logic [4:0] BLANK     = 5'd31
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] seed,
   output logic        wEn,
   output logic [5:0]  wAddr,
   output logic [4:0]  dataIn,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FILL    = 3'd1,
      SHUFFLE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [5:0]  LAST_IDX  = 6'(NUM_CARDS - 1);
   localparam logic [5:0]  CARDS_6   = 6'(NUM_CARDS);
   localparam logic [15:0] LFSR_INIT = 16'hACE1;

   state_t      state_r;
   state_t      next_state_s;
   logic [15:0] lfsr_r;
   logic [5:0]  i_r;
   logic [5:0]  a_r;
   logic [4:0]  deck_r [NUM_CARDS];

   logic [5:0]  j_s;
   logic [5:0]  j_idx_s;
   logic        accept_s;
   logic [5:0]  a_next_s;
   logic [5:0]  rd_idx_s;
   logic [4:0]  card_s;
   logic [4:0]  data_next_s;

   logic        wen_r;
   logic [5:0]  waddr_r;
   logic [4:0]  data_r;
   logic        busy_r;
   logic        done_r;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   assign j_s      = lfsr_r[5:0];
   assign accept_s = (j_s <= i_r);
   assign j_idx_s  = accept_s ? j_s : i_r;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    if (start) next_state_s = FILL; else next_state_s = IDLE;
         FILL:    next_state_s = SHUFFLE;
         SHUFFLE: if (accept_s && (i_r == 6'd1)) next_state_s = WRITE; else next_state_s = SHUFFLE;
         WRITE:   if (a_r == 6'd63) next_state_s = DONE; else next_state_s = WRITE;
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Next write cursor and the card value that goes with it
   always_comb begin
      if (state_r == WRITE) begin
         a_next_s = (a_r == 6'd63) ? a_r : a_r + 6'd1;
      end else begin
         a_next_s = 6'd0;
      end
      rd_idx_s = (a_next_s < CARDS_6) ? a_next_s : 6'd0;
      // On the last shuffle cycle the final swap has not landed yet, so look through it.
      if ((state_r == SHUFFLE) && (rd_idx_s == i_r)) begin
         card_s = deck_r[j_idx_s];
      end else if ((state_r == SHUFFLE) && (rd_idx_s == j_idx_s)) begin
         card_s = deck_r[i_r];
      end else begin
         card_s = deck_r[rd_idx_s];
      end
      if (a_next_s >= CARDS_6) begin
         data_next_s = BLANK;
      end else begin
         data_next_s = card_s;
      end
   end

   // Deck storage: ordered fill, then swaps
   always_ff @(posedge clock) begin
      if (state_r == FILL) begin
         for (int k = 0; k < NUM_CARDS; k++) begin
            deck_r[k] <= 5'(k >> 1);
         end
      end else if ((state_r == SHUFFLE) && accept_s) begin
         deck_r[i_r]     <= deck_r[j_idx_s];
         deck_r[j_idx_s] <= deck_r[i_r];
      end
   end

   // LFSR, shuffle index and write cursor
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_r <= LFSR_INIT;
         i_r    <= 6'd0;
         a_r    <= 6'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) lfsr_r <= (seed == 16'd0) ? LFSR_INIT : seed;
            end
            FILL: begin
               i_r <= LAST_IDX;
            end
            SHUFFLE: begin
               lfsr_r <= lfsr_step(lfsr_r);
               if (accept_s) i_r <= i_r - 6'd1;
            end
            default: begin
            end
         endcase
         if (next_state_s == WRITE) a_r <= a_next_s;
      end
   end

   // Registered outputs, computed from the next state so they line up with it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wen_r   <= 1'b0;
         waddr_r <= 6'd0;
         data_r  <= 5'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         wen_r   <= (next_state_s == WRITE);
         waddr_r <= (next_state_s == WRITE) ? a_next_s : 6'd0;
         data_r  <= (next_state_s == WRITE) ? data_next_s : 5'd0;
         busy_r  <= (next_state_s != IDLE);
         done_r  <= (next_state_s == DONE);
      end
   end

   assign wEn    = wen_r;
   assign wAddr  = waddr_r;
   assign dataIn = data_r;
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter NUM_CARDS, default 36: playable cells of the 6x6 board, i.e. 18 pairs at addresses 0..35.
REQ-002 Parameter BLANK, default 5'd31: card value written to unused addresses 36..63.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to shuffle and deal a new board.
REQ-006 seed  input  16  LFSR seed, sampled on the accepted start cycle.
REQ-007 wEn  output  1  write enable to the 64-entry card memory.
REQ-008 wAddr  output  6  card memory write address.
REQ-009 dataIn  output  5  card value written at wAddr.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse when the whole memory has been written.

Function
REQ-012 States: IDLE, FILL, SHUFFLE, WRITE, DONE.
REQ-013 IDLE: start=1 is accepted; LFSR <= seed, or 16'hACE1 if seed==0; next state FILL.
REQ-014 start while not in IDLE: ignored, no effect on state or outputs.
REQ-015 Internal deck is 36 x 5-bit registers.
REQ-016 FILL (exactly 1 cycle): deck[k] <= k>>1 for k=0..35, giving values 0..17 twice each; index i <= 35; next state SHUFFLE.
REQ-017 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
REQ-018 LFSR advances exactly once per SHUFFLE cycle and is frozen in all other states.
REQ-019 SHUFFLE, each cycle: j = current LFSR[5:0] (value before the advance).
- If j <= i: swap deck[i] and deck[j] (j==i is a legal no-op swap), then i <= i-1.
- Otherwise: reject, i unchanged.
REQ-020 SHUFFLE exits to WRITE in the cycle after the swap with i==1 completes; cursor a <= 0.
REQ-021 WRITE, one write per cycle for a=0..63: wEn=1, wAddr=a, dataIn=deck[a] for a<36, else BLANK.
REQ-022 WRITE exits to DONE after a==63; 64 consecutive write cycles with no gaps.
REQ-023 DONE: done=1 for 1 cycle, then IDLE.
REQ-024 wEn=0, wAddr=0, dataIn=0 in every state except WRITE.
REQ-025 Outputs wEn, wAddr, dataIn, busy and done are registered (no combinational path from inputs).
REQ-026 busy=1 in FILL, SHUFFLE, WRITE and DONE; busy=0 in IDLE.
REQ-027 Invariant: after done, addresses 0..35 hold each value 0..17 exactly twice, for any seed.
REQ-028 Address arithmetic is 6-bit with no wrap; the cursor never exceeds 63.

Reset
REQ-029 reset_n=0 at any time, including mid-SHUFFLE or mid-WRITE, immediately forces: state IDLE, wEn=0, wAddr=0, dataIn=0, busy=0, done=0, i=0, a=0, LFSR=16'hACE1.
REQ-030 A write sequence interrupted by reset is not resumed; the next start re-deals the full memory.
REQ-031 Deck contents after reset are don't-care until FILL.
REQ-032 First start is accepted on the first posedge after reset_n deasserts.

Verification
REQ-033 Reset, then start with seed=16'h0001 -> busy rises next cycle; exactly 64 wEn cycles with wAddr 0..63 in order; done is a single pulse; addresses 0..35 form 18 pairs; addresses 36..63 hold 31.
REQ-034 start with seed=0 -> written sequence identical to a run with seed=16'hACE1.
REQ-035 Re-run with the same seed twice -> identical written data; seeds 16'h1234 vs 16'h4321 -> differing sequences, pair invariant holds for both.
REQ-036 Pulse start repeatedly during SHUFFLE and WRITE -> no restart; output matches a single-start run.
REQ-037 Assert reset_n=0 at write cycle 20 -> wEn drops asynchronously; after release, state is IDLE with no done pulse.
REQ-038 Scoreboard: a C model of REQ-016..019 driven with 200 random seeds -> every written word matches the model exactly.
